dual_clear_counter: RTL and testbench

- Modulo up/down counter. It is the consumer of the `rst`/`rst2` clear-request pair produced by the `sel`-driven reset generator in the counter project.
- `clr` (driven from `rst`) is the primary synchronous clear. `clr2` (driven from `rst2`) is the secondary synchronous reload.
- A small run-control FSM gates counting. A parameterised one-shot mode stops the counter at the terminal count.
- Instantiated beside the reset generator and driven by its outputs.

---
 rtl/dual_clear_counter.sv | 105 ++++++++++
 tb/tb_dual_clear_counter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dual_clear_counter.sv
// rtl/dual_clear_counter.sv - modulo up/down counter with primary clear, secondary reload and run-control FSM
module dual_clear_counter #(
  parameter int WIDTH   = 8,
  parameter int MAX     = 9,
  parameter int LOAD    = 0,
  parameter int ONESHOT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             clr2,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] LOAD_V = WIDTH'(LOAD);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic step;
  logic at_term;

  // A count step happens only when no clear/reload is pending and the FSM is not parked in DONE
  assign step = en && (state_q != DONE) && !clr && !clr2;

  // Terminal in either direction; values above MAX (only reachable via LOAD) count as terminal
  assign at_term = up ? (cnt >= MAX_V) : ((cnt == '0) || (cnt > MAX_V));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: clr forces IDLE, clr2 only releases DONE, a one-shot wrap parks in DONE
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else if (clr2) begin
      if (state_q == DONE) begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE:    if (en)  state_d = RUN;
        RUN:     if (!en) state_d = PAUSE;
        PAUSE:   if (en)  state_d = RUN;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
      if ((ONESHOT != 0) && step && at_term) begin
        state_d = DONE;
      end
    end
  end

  // FSM outputs decoded from the registered state
  always_comb begin
    busy = (state_q == RUN);
    done = (ONESHOT != 0) && (state_q == DONE);
  end

  // Count register and one-cycle wrap pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (clr2) begin
      cnt  <= LOAD_V;
      wrap <= 1'b0;
    end else if (step) begin
      if (at_term) begin
        cnt  <= up ? '0 : MAX_V;
        wrap <= 1'b1;
      end else begin
        cnt  <= up ? (cnt + ONE_V) : (cnt - ONE_V);
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dual_clear_counter.sv
// tb/tb_dual_clear_counter.sv - directed self-checking bench for dual_clear_counter
module tb_dual_clear_counter;

  logic       clk;
  logic       rst_n;
  // instance a: MAX=9, LOAD=7, free-running
  logic       clr_a, clr2_a, en_a, up_a;
  logic [7:0] cnt_a;
  logic       wrap_a, busy_a, done_a;
  // instance b: MAX=3, LOAD=5 (out of range), one-shot
  logic       clr_b, clr2_b, en_b, up_b;
  logic [7:0] cnt_b;
  logic       wrap_b, busy_b, done_b;

  int n_checks;
  int n_fail;

  dual_clear_counter #(.WIDTH(8), .MAX(9), .LOAD(7), .ONESHOT(0)) u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_a),
    .clr2 (clr2_a),
    .en   (en_a),
    .up   (up_a),
    .cnt  (cnt_a),
    .wrap (wrap_a),
    .busy (busy_a),
    .done (done_a)
  );

  dual_clear_counter #(.WIDTH(8), .MAX(3), .LOAD(5), .ONESHOT(1)) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_b),
    .clr2 (clr2_b),
    .en   (en_b),
    .up   (up_b),
    .cnt  (cnt_b),
    .wrap (wrap_b),
    .busy (busy_b),
    .done (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input int c, input int w, input int b);
    check_eq({tag, ".cnt"},  32'(cnt_a),  32'(c));
    check_eq({tag, ".wrap"}, 32'(wrap_a), 32'(w));
    check_eq({tag, ".busy"}, 32'(busy_a), 32'(b));
    check_eq({tag, ".done"}, 32'(done_a), 32'd0);
  endtask

  task automatic check_b(input string tag, input int c, input int w, input int b, input int d);
    check_eq({tag, ".cnt"},  32'(cnt_b),  32'(c));
    check_eq({tag, ".wrap"}, 32'(wrap_b), 32'(w));
    check_eq({tag, ".busy"}, 32'(busy_b), 32'(b));
    check_eq({tag, ".done"}, 32'(done_b), 32'(d));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    clr_a = 1'b0; clr2_a = 1'b0; en_a = 1'b0; up_a = 1'b1;
    clr_b = 1'b0; clr2_b = 1'b0; en_b = 1'b0; up_b = 1'b1;

    // reset for two cycles
    tick();
    tick();
    check_a("reset_a", 0, 0, 0);
    check_b("reset_b", 0, 0, 0, 0);

    // basic up count through the wrap
    rst_n = 1'b1;
    en_a  = 1'b1;
    up_a  = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check_a($sformatf("basic%0d", i), i % 10, (i == 10) ? 1 : 0, 1);
    end
    for (int i = 0; i < 3; i++) tick();
    check_a("pre_clr", 5, 0, 1);

    // clr beats clr2 and en
    clr_a = 1'b1; clr2_a = 1'b1;
    tick();
    check_a("clr_prio", 0, 0, 0);
    clr_a = 1'b0; clr2_a = 1'b0;

    // reload to LOAD with no step, FSM stays RUN
    for (int i = 0; i < 3; i++) tick();
    check_a("pre_reload", 3, 0, 1);
    clr2_a = 1'b1;
    tick();
    check_a("reload", 7, 0, 1);
    clr2_a = 1'b0;
    tick();
    check_a("after_reload", 8, 0, 1);
    en_a = 1'b0;
    tick();
    check_a("pause", 8, 0, 0);
    tick();
    check_a("pause_hold", 8, 0, 0);

    // count down to 1, then wrap down and turn around
    en_a = 1'b1;
    up_a = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check_a("down_to1", 1, 0, 1);
    tick();
    check_a("down_to0", 0, 0, 1);
    tick();
    check_a("down_wrap", 9, 1, 1);
    up_a = 1'b1;
    tick();
    check_a("up_wrap", 0, 1, 1);
    tick();
    check_a("up_after", 1, 0, 1);

    // async reset between edges
    for (int i = 0; i < 5; i++) tick();
    check_a("pre_async", 6, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_a("async_rst", 0, 0, 0);
    tick();
    check_a("async_hold", 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check_a("async_resume", 1, 0, 1);
    en_a = 1'b0;

    // one-shot instance: 1,2,3,0 then parked in DONE
    en_b = 1'b1;
    up_b = 1'b1;
    tick(); check_b("os1", 1, 0, 1, 0);
    tick(); check_b("os2", 2, 0, 1, 0);
    tick(); check_b("os3", 3, 0, 1, 0);
    tick(); check_b("os_wrap", 0, 1, 0, 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_b($sformatf("os_hold%0d", i), 0, 0, 0, 1);
    end

    // clr2 releases DONE and loads the out-of-range value
    en_b   = 1'b0;
    clr2_b = 1'b1;
    tick();
    check_b("os_reload", 5, 0, 0, 0);
    clr2_b = 1'b0;
    en_b   = 1'b1;
    tick();
    check_b("os_oor_up", 0, 1, 0, 1);

    // clr clears DONE, then a down step from 0 wraps to MAX and parks again
    clr_b = 1'b1;
    tick();
    check_b("os_clr", 0, 0, 0, 0);
    clr_b = 1'b0;
    up_b  = 1'b0;
    tick();
    check_b("os_down_wrap", 3, 1, 0, 1);
    tick();
    check_b("os_down_hold", 3, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
